// File: rtl/p23_multicycle_ctrl_if.sv
// ============================================================================
// Module  : p23_multicycle_ctrl_if
// Brief   : Control/handshake bundle between the p23 control FSM and datapath.
//           illegal_instr exists only when P23_ILLEGAL_TRAP_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface p23_multicycle_ctrl_if;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_valid;
    logic       mem_we;
    logic       adrsrc;
    logic       irwrite;
    logic       pcupdate;
    logic       regwrite;
    logic [2:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] resultsrc;
`ifdef P23_ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    modport master (
        input  opcode, branch_taken, mem_ready,
        output mem_valid, mem_we, adrsrc, irwrite, pcupdate, regwrite,
        output immsrc, alusrca, alusrcb, aluop, resultsrc
`ifdef P23_ILLEGAL_TRAP_EN
        , output illegal_instr
`endif
    );

    modport slave (
        output opcode, branch_taken, mem_ready,
        input  mem_valid, mem_we, adrsrc, irwrite, pcupdate, regwrite,
        input  immsrc, alusrca, alusrcb, aluop, resultsrc
`ifdef P23_ILLEGAL_TRAP_EN
        , input illegal_instr
`endif
    );
endinterface

`default_nettype wire

// File: rtl/p23_multicycle_ctrl.sv
// ============================================================================
// Module  : p23_multicycle_ctrl
// Brief   : Main multicycle RV32I control FSM with memory valid/ready handshake.
//           Optional P23_ILLEGAL_TRAP_EN adds a sticky TRAP state.
// Revision: 1.0
// ============================================================================
`default_nettype none

module p23_multicycle_ctrl (
    input  wire logic             clk,
    input  wire logic             rst,
    p23_multicycle_ctrl_if.master bus
);
    localparam logic [2:0] c_IMMSRC_ITYPE = 3'd0;
    localparam logic [2:0] c_IMMSRC_STYPE = 3'd1;
    localparam logic [2:0] c_IMMSRC_BTYPE = 3'd2;
    localparam logic [2:0] c_IMMSRC_UTYPE = 3'd3;
    localparam logic [2:0] c_IMMSRC_JTYPE = 3'd4;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTER = 4'd7,
        S_EXECUTEI = 4'd8,
        S_ALUWB    = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_BRANCH   = 4'd12,
`ifdef P23_ILLEGAL_TRAP_EN
        S_TRAP     = 4'd14,
`endif
        S_UPPER    = 4'd13
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic       w_mem_valid;
    logic       w_mem_we;
    logic       w_adrsrc;
    logic       w_irwrite;
    logic       w_pcupdate;
    logic       w_regwrite;
    logic [2:0] w_immsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic [1:0] w_resultsrc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mem_valid  = 1'b0;
        w_mem_we     = 1'b0;
        w_adrsrc     = 1'b0;
        w_irwrite    = 1'b0;
        w_pcupdate   = 1'b0;
        w_regwrite   = 1'b0;
        w_immsrc     = c_IMMSRC_ITYPE;
        w_alusrca    = 2'd0;
        w_alusrcb    = 2'd0;
        w_aluop      = 2'd0;
        w_resultsrc  = 2'd0;

        case (r_state)
            S_IDLE: begin
                w_immsrc     = 3'd0;
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                w_mem_valid = 1'b1;
                w_alusrcb   = 2'd2;
                w_resultsrc = 2'd2;
                // IR load and PC+4 commit only in the cycle the fetch completes
                if (bus.mem_ready) begin
                    w_irwrite    = 1'b1;
                    w_pcupdate   = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alusrca = 2'd1;
                w_alusrcb = 2'd1;
                w_immsrc  = (bus.opcode == c_OP_JAL) ? c_IMMSRC_JTYPE : c_IMMSRC_BTYPE;
                case (bus.opcode)
                    c_OP_LOAD, c_OP_STORE: w_next_state = S_MEMADR;
                    c_OP_RTYPE:            w_next_state = S_EXECUTER;
                    c_OP_ITYPE:            w_next_state = S_EXECUTEI;
                    c_OP_JAL:              w_next_state = S_JAL;
                    c_OP_JALR:             w_next_state = S_JALR;
                    c_OP_BRANCH:           w_next_state = S_BRANCH;
                    c_OP_LUI, c_OP_AUIPC:  w_next_state = S_UPPER;
`ifdef P23_ILLEGAL_TRAP_EN
                    default:               w_next_state = S_TRAP;
`else
                    default:               w_next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 2'd2;
                w_alusrcb = 2'd1;
                if (bus.opcode == c_OP_STORE) begin
                    w_immsrc     = c_IMMSRC_STYPE;
                    w_next_state = S_MEMWRITE;
                end else begin
                    w_next_state = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                w_mem_valid = 1'b1;
                w_adrsrc    = 1'b1;
                if (bus.mem_ready) begin
                    w_next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_resultsrc  = 2'd1;
                w_regwrite   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_valid = 1'b1;
                w_mem_we    = 1'b1;
                w_adrsrc    = 1'b1;
                if (bus.mem_ready) begin
                    w_next_state = S_FETCH;
                end
            end
            S_EXECUTER: begin
                w_alusrca    = 2'd2;
                w_aluop      = 2'd2;
                w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alusrca    = 2'd2;
                w_alusrcb    = 2'd1;
                w_aluop      = 2'd2;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JALR: begin
                // Target lands in ALUOut; JAL then redirects PC and computes the link
                w_alusrca    = 2'd2;
                w_alusrcb    = 2'd1;
                w_next_state = S_JAL;
            end
            S_JAL: begin
                w_alusrca    = 2'd1;
                w_alusrcb    = 2'd2;
                w_pcupdate   = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_BRANCH: begin
                w_alusrca    = 2'd2;
                w_aluop      = 2'd1;
                w_pcupdate   = bus.branch_taken;
                w_next_state = S_FETCH;
            end
            S_UPPER: begin
                w_alusrca    = (bus.opcode == c_OP_AUIPC) ? 2'd1 : 2'd3;
                w_alusrcb    = 2'd1;
                w_immsrc     = c_IMMSRC_UTYPE;
                w_next_state = S_ALUWB;
            end
`ifdef P23_ILLEGAL_TRAP_EN
            S_TRAP: begin
                w_immsrc     = 3'd0;
                w_next_state = S_TRAP;
            end
`endif
            default: begin
                w_immsrc     = 3'd0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign bus.mem_valid = w_mem_valid;
    assign bus.mem_we    = w_mem_we;
    assign bus.adrsrc    = w_adrsrc;
    assign bus.irwrite   = w_irwrite;
    assign bus.pcupdate  = w_pcupdate;
    assign bus.regwrite  = w_regwrite;
    assign bus.immsrc    = w_immsrc;
    assign bus.alusrca   = w_alusrca;
    assign bus.alusrcb   = w_alusrcb;
    assign bus.aluop     = w_aluop;
    assign bus.resultsrc = w_resultsrc;

`ifdef P23_ILLEGAL_TRAP_EN
    // TRAP is left only through reset, so the state itself is the sticky flag
    assign bus.illegal_instr = (r_state == S_TRAP);
`endif

endmodule

`default_nettype wire

// File: tb/tb_p23_multicycle_ctrl.sv
// ============================================================================
// Module  : tb_p23_multicycle_ctrl
// Brief   : Scoreboard bench for p23_multicycle_ctrl; expected output vectors
//           are queued per cycle and compared mid-cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_p23_multicycle_ctrl;
    localparam logic [2:0] c_I = 3'd0;
    localparam logic [2:0] c_S = 3'd1;
    localparam logic [2:0] c_B = 3'd2;
    localparam logic [2:0] c_U = 3'd3;
    localparam logic [2:0] c_J = 3'd4;

    localparam logic [6:0] c_LOAD  = 7'b0000011;
    localparam logic [6:0] c_STORE = 7'b0100011;
    localparam logic [6:0] c_RTYPE = 7'b0110011;
    localparam logic [6:0] c_ITYPE = 7'b0010011;
    localparam logic [6:0] c_JAL   = 7'b1101111;
    localparam logic [6:0] c_JALR  = 7'b1100111;
    localparam logic [6:0] c_BR    = 7'b1100011;
    localparam logic [6:0] c_LUI   = 7'b0110111;
    localparam logic [6:0] c_AUIPC = 7'b0010111;
    localparam logic [6:0] c_ILL   = 7'b0000000;

    logic clk;
    logic rst;
    int   r_tests;
    int   r_fails;

    logic [17:0] r_exp_q[$];
    string       r_tag_q[$];

    p23_multicycle_ctrl_if bus();

    p23_multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic w_ill;
`ifdef P23_ILLEGAL_TRAP_EN
    assign w_ill = bus.illegal_instr;
`else
    assign w_ill = 1'b0;
`endif

    // {illegal, mem_valid, mem_we, adrsrc, irwrite, pcupdate, regwrite,
    //  immsrc, alusrca, alusrcb, aluop, resultsrc}
    logic [17:0] w_obs;
    assign w_obs = {w_ill, bus.mem_valid, bus.mem_we, bus.adrsrc, bus.irwrite,
                    bus.pcupdate, bus.regwrite, bus.immsrc, bus.alusrca,
                    bus.alusrcb, bus.aluop, bus.resultsrc};

    task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
        r_tests++;
        if (got !== exp) begin
            r_fails++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] ov(input bit mv, input bit we, input bit adr,
                                       input bit irw, input bit pcu, input bit rw,
                                       input logic [2:0] imm, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] op,
                                       input logic [1:0] rs);
        return {1'b0, mv, we, adr, irw, pcu, rw, imm, a, b, op, rs};
    endfunction

    // One clock: drive mem_ready at the falling edge, queue expectation, check 1ns later
    task automatic cyc(input string tag, input bit rdy, input logic [17:0] exp);
        logic [17:0] e;
        string       t;
        @(negedge clk);
        bus.mem_ready = rdy;
        r_exp_q.push_back(exp);
        r_tag_q.push_back(tag);
        #1;
        e = r_exp_q.pop_front();
        t = r_tag_q.pop_front();
        chk(t, w_obs, e);
    endtask

    function automatic bit rnd();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input string nm, input logic [6:0] op, input bit bt,
                             input int fw, input int mw);
        logic [17:0] e_fwait;
        logic [17:0] e_mem;
        e_fwait = ov(1,0,0,0,0,0,c_I,2'd0,2'd2,2'd0,2'd2);
        bus.opcode       = op;
        bus.branch_taken = bt;
        for (int i = 0; i < fw; i++) cyc({nm, ".fetch_wait"}, 1'b0, e_fwait);
        cyc({nm, ".fetch"}, 1'b1, ov(1,0,0,1,1,0,c_I,2'd0,2'd2,2'd0,2'd2));
        cyc({nm, ".decode"}, rnd(),
            ov(0,0,0,0,0,0,(op == c_JAL) ? c_J : c_B,2'd1,2'd1,2'd0,2'd0));
        case (op)
            c_LOAD: begin
                cyc({nm, ".memadr"}, rnd(), ov(0,0,0,0,0,0,c_I,2'd2,2'd1,2'd0,2'd0));
                e_mem = ov(1,0,1,0,0,0,c_I,2'd0,2'd0,2'd0,2'd0);
                for (int i = 0; i < mw; i++) cyc({nm, ".memread_wait"}, 1'b0, e_mem);
                cyc({nm, ".memread"}, 1'b1, e_mem);
                cyc({nm, ".memwb"}, rnd(), ov(0,0,0,0,0,1,c_I,2'd0,2'd0,2'd0,2'd1));
            end
            c_STORE: begin
                cyc({nm, ".memadr"}, rnd(), ov(0,0,0,0,0,0,c_S,2'd2,2'd1,2'd0,2'd0));
                e_mem = ov(1,1,1,0,0,0,c_I,2'd0,2'd0,2'd0,2'd0);
                for (int i = 0; i < mw; i++) cyc({nm, ".memwrite_wait"}, 1'b0, e_mem);
                cyc({nm, ".memwrite"}, 1'b1, e_mem);
            end
            c_RTYPE: begin
                cyc({nm, ".executer"}, rnd(), ov(0,0,0,0,0,0,c_I,2'd2,2'd0,2'd2,2'd0));
                cyc({nm, ".aluwb"}, rnd(), ov(0,0,0,0,0,1,c_I,2'd0,2'd0,2'd0,2'd0));
            end
            c_ITYPE: begin
                cyc({nm, ".executei"}, rnd(), ov(0,0,0,0,0,0,c_I,2'd2,2'd1,2'd2,2'd0));
                cyc({nm, ".aluwb"}, rnd(), ov(0,0,0,0,0,1,c_I,2'd0,2'd0,2'd0,2'd0));
            end
            c_JAL, c_JALR: begin
                if (op == c_JALR)
                    cyc({nm, ".jalr"}, rnd(), ov(0,0,0,0,0,0,c_I,2'd2,2'd1,2'd0,2'd0));
                cyc({nm, ".jal"}, rnd(), ov(0,0,0,0,1,0,c_I,2'd1,2'd2,2'd0,2'd0));
                cyc({nm, ".aluwb"}, rnd(), ov(0,0,0,0,0,1,c_I,2'd0,2'd0,2'd0,2'd0));
            end
            c_BR: begin
                cyc({nm, ".branch"}, rnd(), ov(0,0,0,0,bt,0,c_I,2'd2,2'd0,2'd1,2'd0));
            end
            c_LUI, c_AUIPC: begin
                cyc({nm, ".upper"}, rnd(),
                    ov(0,0,0,0,0,0,c_U,(op == c_AUIPC) ? 2'd1 : 2'd3,2'd1,2'd0,2'd0));
                cyc({nm, ".aluwb"}, rnd(), ov(0,0,0,0,0,1,c_I,2'd0,2'd0,2'd0,2'd0));
            end
            default: begin
`ifdef P23_ILLEGAL_TRAP_EN
                for (int i = 0; i < 10; i++) cyc({nm, ".trap"}, rnd(), 18'h20000);
`else
                cyc({nm, ".refetch"}, 1'b0, e_fwait);
`endif
            end
        endcase
    endtask

    // Asynchronous reset pulse mid-cycle, then release and check IDLE
    task automatic do_reset(input string nm);
        #2 rst = 1'b1;
        #1 chk({nm, ".async"}, w_obs, 18'h0);
        @(negedge clk);
        chk({nm, ".held"}, w_obs, 18'h0);
        rst = 1'b0;
        #1 chk({nm, ".idle"}, w_obs, 18'h0);
    endtask

    initial begin
        r_tests          = 0;
        r_fails          = 0;
        rst              = 1'b1;
        bus.opcode       = 7'd0;
        bus.branch_taken = 1'b0;
        bus.mem_ready    = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("reset", w_obs, 18'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("idle", w_obs, 18'h0);

        run_instr("addi",      c_ITYPE, 1'b0, 0, 0);
        run_instr("lw",        c_LOAD,  1'b0, 1, 3);
        run_instr("sw",        c_STORE, 1'b1, 0, 2);
        run_instr("add",       c_RTYPE, 1'b1, 2, 0);
        run_instr("beq_t",     c_BR,    1'b1, 0, 0);
        run_instr("beq_nt",    c_BR,    1'b0, 1, 0);
        run_instr("jal",       c_JAL,   1'b0, 0, 0);
        run_instr("lui",       c_LUI,   1'b1, 0, 0);
        run_instr("auipc",     c_AUIPC, 1'b0, 0, 0);
        run_instr("jalr",      c_JALR,  1'b1, 0, 0);
        run_instr("lw0",       c_LOAD,  1'b0, 0, 0);
        run_instr("sw0",       c_STORE, 1'b0, 0, 0);

        // Abort a load stalled in MEMREAD
        bus.opcode = c_LOAD;
        cyc("rst_mr.fetch", 1'b1, ov(1,0,0,1,1,0,c_I,2'd0,2'd2,2'd0,2'd2));
        cyc("rst_mr.decode", 1'b0, ov(0,0,0,0,0,0,c_B,2'd1,2'd1,2'd0,2'd0));
        cyc("rst_mr.memadr", 1'b0, ov(0,0,0,0,0,0,c_I,2'd2,2'd1,2'd0,2'd0));
        cyc("rst_mr.memread", 1'b0, ov(1,0,1,0,0,0,c_I,2'd0,2'd0,2'd0,2'd0));
        do_reset("rst_mr");
        cyc("rst_mr.refetch", 1'b0, ov(1,0,0,0,0,0,c_I,2'd0,2'd2,2'd0,2'd2));

        run_instr("ill", c_ILL, 1'b0, 0, 0);
`ifdef P23_ILLEGAL_TRAP_EN
        do_reset("trap_rst");
`endif
        run_instr("addi2", c_ITYPE, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire

// File: doc/p23_multicycle_ctrl.md
# p23_multicycle_ctrl

Main control FSM for the p23 multicycle RV32I datapath. It sequences fetch, decode, execute, memory and writeback, and drives the datapath mux selects, including `immsrc` to the immediate extender. It runs a valid/ready handshake with the unified memory port. The decode inputs come from the instruction register, which this block loads via `irwrite`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `opcode`  in  7  instr[6:0] from the instruction register; valid from DECODE onward
- `branch_taken`  in  1  branch condition from ALU flags and funct3, evaluated externally
- `mem_ready`  in  1  memory completes the current access
- `mem_valid`  out  1  memory request
- `mem_we`  out  1  write request, qualified by `mem_valid`
- `adrsrc`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `irwrite`  out  1  load the instruction register
- `pcupdate`  out  1  load PC from the result bus
- `regwrite`  out  1  register file write enable
- `immsrc`  out  3  `IMMSRC_*` code from riscv_defines.vh
- `alusrca`  out  2  0 = PC, 1 = oldPC, 2 = rs1, 3 = zero
- `alusrcb`  out  2  0 = rs2, 1 = immext, 2 = constant 4
- `aluop`  out  2  0 = add, 1 = branch compare, 2 = funct-decoded
- `resultsrc`  out  2  0 = ALUOut, 1 = memory data, 2 = ALU result
- `illegal_instr`  out  1  sticky illegal-opcode flag; present only with `P23_ILLEGAL_TRAP_EN`

## Operation
Output rules:
- Outputs decode from the state register (Moore), except `irwrite`/`pcupdate` in FETCH and `pcupdate` in BRANCH.
- Every output not listed for a state is 0, except `immsrc`, which defaults to `IMMSRC_ITYPE`.

States:
- IDLE (reset state): all outputs 0 → FETCH unconditionally.
- FETCH: `mem_valid`=1, `adrsrc`=0, `alusrca`=0, `alusrcb`=2, `resultsrc`=2.
  - Holds while `mem_ready`=0.
  - In the cycle `mem_ready`=1: `irwrite`=1, `pcupdate`=1 → DECODE.
- DECODE: `alusrca`=1, `alusrcb`=1, `immsrc`=J if opcode is 1101111, else B. Next state by opcode:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1101111 → JAL
  - 1100111 → JALR
  - 1100011 → BRANCH
  - 0110111 / 0010111 → UPPER
  - any other opcode → illegal (see Configuration)
- MEMADR: `alusrca`=2, `alusrcb`=1, `immsrc`=S for store, I for load → MEMWRITE (store) or MEMREAD (load).
- MEMREAD: `mem_valid`=1, `adrsrc`=1; waits for `mem_ready` → MEMWB.
- MEMWB: `resultsrc`=1, `regwrite`=1 → FETCH.
- MEMWRITE: `mem_valid`=1, `mem_we`=1, `adrsrc`=1; waits for `mem_ready` → FETCH.
- EXECUTER: `alusrca`=2, `alusrcb`=0, `aluop`=2 → ALUWB.
- EXECUTEI: `alusrca`=2, `alusrcb`=1, `aluop`=2 → ALUWB.
- ALUWB: `resultsrc`=0, `regwrite`=1 → FETCH.
- JALR: `alusrca`=2, `alusrcb`=1, `immsrc`=I → JAL.
- JAL: `alusrca`=1, `alusrcb`=2, `resultsrc`=0, `pcupdate`=1 → ALUWB.
- BRANCH: `alusrca`=2, `alusrcb`=0, `aluop`=1, `resultsrc`=0, `pcupdate`=`branch_taken` → FETCH.
- UPPER: `alusrca`=1 for auipc, 3 for lui; `alusrcb`=1, `immsrc`=U → ALUWB.

## Timing
- Reset: `rst` high forces IDLE immediately (asynchronous), from any state including a pending memory access. All outputs read 0, `mem_valid` included.
- First FETCH request is presented one cycle after `rst` deasserts.
- Handshake:
  - `mem_valid` stays high, with `mem_we`/`adrsrc` stable, until the cycle `mem_ready`=1.
  - `mem_ready` is ignored in states with `mem_valid`=0.
  - A zero-wait memory (`mem_ready` tied high) completes each access in one cycle.
- Cycle counts with zero-wait memory, FETCH to next FETCH:
  - R/I-ALU, lui, auipc, jal: 4
  - load: 5
  - store: 4
  - branch: 3
  - jalr: 5
- `opcode` is sampled only in DECODE, MEMADR and UPPER. The instruction register changes only with `irwrite`.

## Configuration
- `P23_ILLEGAL_TRAP_EN` defined:
  - Illegal opcode in DECODE → TRAP state; all outputs 0.
  - `illegal_instr`=1 from TRAP entry until reset.
  - TRAP is exited only by `rst`.
- Not defined:
  - Illegal opcode in DECODE → FETCH, i.e. a NOP; PC was already advanced in FETCH.
  - No TRAP state and no `illegal_instr` port.

## Test plan
- Reset mid-MEMREAD with `mem_ready`=0 → all outputs 0 at once; `mem_valid`=1 with `adrsrc`=0 one cycle after release.
- `addi` (0010011), zero-wait memory → `immsrc`=ITYPE in EXECUTEI; `regwrite` pulses once, 4 cycles after the FETCH request.
- `lw` with `mem_ready` delayed 3 cycles in MEMREAD → `mem_valid`/`adrsrc`=1 held 4 cycles, then MEMWB with `resultsrc`=1, `regwrite`=1.
- `beq` with `branch_taken`=1, then again with 0 → `pcupdate` 1 / 0 in BRANCH; DECODE `immsrc`=BTYPE in both cases.
- `jal`, then `lui` → DECODE `immsrc`=JTYPE with `pcupdate` in JAL; UPPER `alusrca`=3, `immsrc`=UTYPE.
- Opcode 0000000 → with the macro: TRAP, `illegal_instr`=1 held for 10 cycles until reset; without it: back in FETCH 2 cycles after the fetch completes.
